// File: rtl/time_display.sv
// Four-digit multiplexed seven-segment driver: splits hour/minute into decimal
// digits, scans them onto a common-anode display and blinks the digit being edited.
module time_display #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] hour,
  input  logic [5:0] minute,
  input  logic [2:0] twinkle,
  output logic [7:0] seg_n,
  output logic [3:0] an_n
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [SW-1:0] SC_LAST = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BC_LAST = BW'(BLINK_DIV - 1);

  logic [5:0]    h_q, m_q;
  logic [2:0]    t_q, t_prev;
  logic [SW-1:0] sc;
  logic [BW-1:0] bc;
  logic [1:0]    idx;
  logic          phase;

  logic          t_chg;
  logic [3:0]    digit;
  logic          blank;
  logic [6:0]    pat;
  logic [3:0]    an_d;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q    <= '0;
      m_q    <= '0;
      t_q    <= 3'd4;
      t_prev <= 3'd4;
    end else begin
      h_q    <= hour;
      m_q    <= minute;
      t_q    <= twinkle;
      t_prev <= t_q;
    end
  end

  assign t_chg = (t_q != t_prev);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sc  <= '0;
      idx <= '0;
    end else if (sc == SC_LAST) begin
      sc  <= '0;
      idx <= idx + 2'd1;
    end else begin
      sc  <= sc + 1'b1;
    end
  end

  // A change of edit position restarts the blink so the new digit shows at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bc    <= '0;
      phase <= 1'b0;
    end else if (t_chg) begin
      bc    <= '0;
      phase <= 1'b0;
    end else if (bc == BC_LAST) begin
      bc    <= '0;
      phase <= ~phase;
    end else begin
      bc    <= bc + 1'b1;
    end
  end

  always_comb begin
    digit = '0;
    an_d  = 4'b1111;
    case (idx)
      2'd0: begin digit = 4'(h_q / 6'd10); an_d = 4'b0111; end
      2'd1: begin digit = 4'(h_q % 6'd10); an_d = 4'b1011; end
      2'd2: begin digit = 4'(m_q / 6'd10); an_d = 4'b1101; end
      default: begin digit = 4'(m_q % 6'd10); an_d = 4'b1110; end
    endcase
    blank = (t_q < 3'd4) && (t_q[1:0] == idx) && phase;
    pat   = blank ? 7'b1111111 : seg7(digit);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_n <= 8'hFF;
      an_n  <= 4'hF;
    end else begin
      seg_n <= {(idx != 2'd1), pat};
      an_n  <= an_d;
    end
  end

endmodule

// File: tb/tb_time_display.sv
// Randomized bench for time_display; expected outputs come from an arithmetic
// model indexed by clock edges since reset release.
module tb_time_display;

  localparam int S = 4;
  localparam int B = 16;
  localparam int HN = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] hour = '0;
  logic [5:0] minute = '0;
  logic [2:0] twinkle = 3'd4;
  logic [7:0] seg_n;
  logic [3:0] an_n;

  int n_cmp = 0;
  int n_bad = 0;
  int k;
  int hist_h[HN];
  int hist_m[HN];
  int hist_t[HN];

  time_display #(.SCAN_DIV(S), .BLINK_DIV(B)) dut (
    .clk(clk), .rst(rst), .hour(hour), .minute(minute),
    .twinkle(twinkle), .seg_n(seg_n), .an_n(an_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s k=%0d got=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic reset_model();
    k = 0;
    for (int i = 0; i < HN; i++) begin
      hist_h[i] = 0;
      hist_m[i] = 0;
      hist_t[i] = 4;
    end
  endtask

  // Registered twinkle value after edge i.
  function automatic int tq(input int i);
    return (i <= 0) ? 4 : hist_t[i];
  endfunction

  // Blink phase after edge j: counts half-periods since the most recent clear.
  function automatic int phase_at(input int j);
    int c = 0;
    for (int i = j; i >= 1; i--) begin
      if (tq(i - 1) != tq(i - 2)) begin
        c = i;
        break;
      end
    end
    return ((j - c) / B) % 2;
  endfunction

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check_out();
    int idx, hv, mv, tv, ph, d;
    bit blank;
    logic [7:0] es;
    logic [3:0] ea;
    idx = ((k - 1) / S) % 4;
    hv  = hist_h[k - 1];
    mv  = hist_m[k - 1];
    tv  = tq(k - 1);
    ph  = phase_at(k - 1);
    case (idx)
      0: d = hv / 10;
      1: d = hv % 10;
      2: d = mv / 10;
      default: d = mv % 10;
    endcase
    blank = (tv < 4) && ((tv % 4) == idx) && (ph == 1);
    es = {(idx != 1), blank ? 7'b1111111 : pat(d)};
    ea = 4'b1111 ^ (4'b1000 >> idx);
    chk("seg", seg_n, es);
    chk("an", {4'b0, an_n}, {4'b0, ea});
  endtask

  task automatic step(input int h, input int m, input int t);
    hour    = 6'(h);
    minute  = 6'(m);
    twinkle = 3'(t);
    hist_h[k + 1] = h;
    hist_m[k + 1] = m;
    hist_t[k + 1] = t;
    @(negedge clk);
    k++;
    check_out();
  endtask

  task automatic sync_reset();
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_seg", seg_n, 8'hFF);
    chk("rst_an", {4'b0, an_n}, 8'h0F);
    rst = 1'b1;
    reset_model();
  endtask

  initial begin
    int h, m, t, guard;
    reset_model();
    sync_reset();

    step(23, 45, 4);
    step(23, 45, 4);
    chk("first_an", {4'b0, an_n}, 8'h07);
    chk("first_seg", seg_n, {1'b1, 7'b0100100});
    repeat (64) step(23, 45, 4);

    repeat (80) step(23, 45, 2);

    guard = 0;
    while (phase_at(k) != 1 && guard < 100) begin
      step(23, 45, 2);
      guard++;
    end
    chk("reach_blank", 8'(phase_at(k)), 8'd1);
    repeat (40) step(23, 45, 3);

    repeat (20) step(63, 0, 4);

    h = 12; m = 34; t = 4;
    repeat (600) begin
      if ($urandom_range(0, 19) == 0) t = $urandom_range(0, 7);
      if ($urandom_range(0, 49) == 0) begin
        h = $urandom_range(0, 63);
        m = $urandom_range(0, 63);
      end
      step(h, m, t);
    end

    // Mid-scan asynchronous reset at sc=2, idx=3.
    sync_reset();
    repeat (14) step(59, 17, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_seg", seg_n, 8'hFF);
    chk("arst_an", {4'b0, an_n}, 8'h0F);
    repeat (3) @(negedge clk);
    chk("arst_hold_seg", seg_n, 8'hFF);
    rst = 1'b1;
    reset_model();
    repeat (20) step(8, 19, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
